spi_regbank_subnode: RTL

Parameterised SPI subnode (mode 0, MSB-first) that owns a bank of NUM_REGS general-purpose REG_W-bit registers, plus a control/status register, all in the clk domain. It replaces the fixed three-register subnode: register count, width and sync depth are now configurable. It adds framed read/write commands with abort handling, coherent read snapshots, and a start/busy/done handshake to the crypto core. It sits between the top-level IO pins and the accelerator core.

---
 rtl/spi_regbank_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/spi_regbank_subnode.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register-bank subnode.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_WAIT_CS = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_CTRL      = 4'hF;
    localparam int         CMD_W          = 8;
    localparam int         CMD_WRITE_BIT  = 7;
    localparam int         CTRL_START_BIT = 7;

    // Status byte bit positions
    localparam int BUSY = 0;
    localparam int DONE = 1;
    localparam int ERR  = 2;

    // Assemble the status byte; unused upper bits read as zero.
    function automatic logic [7:0] pack_status(input logic busy, input logic done, input logic err);
        logic [7:0] s;
        s       = '0;
        s[BUSY] = busy;
        s[DONE] = done;
        s[ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchroniser for one raw input pin, with configurable depth and reset value.
module sync_2ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pin value through the chain; reset loads the idle level of the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_regbank_subnode.sv
// SPI mode-0 subnode owning a configurable register bank plus a control/status
// register, with framed commands, coherent read snapshots and a start/busy/done
// handshake towards the accelerator core.
module spi_regbank_subnode
    import spi_regbank_pkg::*;
#(
    parameter int NUM_REGS    = 3,
    parameter int REG_W       = 128,
    parameter int SYNC_STAGES = 2,
    parameter int MODE_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sck,
    input  logic                      csb,
    input  logic                      mosi,
    output logic                      miso,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    input  logic                      core_wr_en,
    input  logic [3:0]                core_wr_sel,
    input  logic [REG_W-1:0]          core_wr_data,
    output logic [MODE_W-1:0]         op_mode,
    output logic                      op_start,
    input  logic                      op_busy,
    input  logic                      op_done
);

    localparam int         CNT_W   = $clog2(REG_W + 1);
    localparam logic [2:0] PIN_RST = 3'b010;  // {mosi, csb, sck} idle levels

    logic [2:0] pins;
    logic [2:0] pins_sync;
    logic       sck_sync, csb_sync, mosi_sync;
    logic       sck_q, csb_q;
    logic       sck_rise, sck_fall, csb_fall;

    state_t             state_reg, state_next;
    logic [CMD_W-1:0]   cmd_reg;
    logic [CMD_W-1:0]   cmd_full;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   data_len;
    logic [REG_W-1:0]   shift_reg;
    logic [REG_W-1:0]   snap_word;
    logic [REG_W-1:0]   regs [NUM_REGS];
    logic               done_flag, err_flag;

    logic [3:0] cur_addr, snap_addr;
    logic       cur_is_reg, cur_is_ctrl, cur_write;
    logic       cmd_shift, cmd_done, data_shift_in, data_shift_out, data_done;
    logic       wr_commit, rd_commit, err_set, status_clr, start_req;

    assign pins = {mosi, csb, sck};

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            for (genvar gi = 0; gi < 3; gi++) begin : g_pin
                sync_2ff #(
                    .STAGES  (SYNC_STAGES),
                    .RST_VAL (PIN_RST[gi])
                ) u_sync (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .d     (pins[gi]),
                    .q     (pins_sync[gi])
                );
            end
        end else begin : g_bypass
            assign pins_sync = pins;
        end
    endgenerate

    assign sck_sync  = pins_sync[0];
    assign csb_sync  = pins_sync[1];
    assign mosi_sync = pins_sync[2];

    // Delayed copies of sck/csb for edge detection in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b0;
            csb_q <= 1'b1;
        end else begin
            sck_q <= sck_sync;
            csb_q <= csb_sync;
        end
    end

    assign sck_rise = sck_sync & ~sck_q;
    assign sck_fall = ~sck_sync & sck_q;
    assign csb_fall = ~csb_sync & csb_q;

    // Command decode: the complete byte is cmd_full on the 8th rise, cmd_reg afterwards.
    assign cmd_full    = {cmd_reg[CMD_W-2:0], mosi_sync};
    assign snap_addr   = cmd_full[3:0];
    assign cur_addr    = cmd_reg[3:0];
    assign cur_write   = cmd_reg[CMD_WRITE_BIT];
    assign cur_is_ctrl = (cur_addr == ADDR_CTRL);
    assign cur_is_reg  = (32'(cur_addr) < NUM_REGS);
    assign data_len    = cur_is_reg ? CNT_W'(REG_W) : CNT_W'(8);

    // Read snapshot, MSB-aligned so every target shifts out of the same bit.
    always_comb begin
        snap_word = '0;
        if (snap_addr == ADDR_CTRL) begin
            snap_word = REG_W'(pack_status(op_busy, done_flag, err_flag)) << (REG_W - 8);
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (snap_addr == 4'(i)) snap_word = regs[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state; csb high aborts from anywhere.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (csb_fall)  state_next = ST_CMD;
            ST_CMD:     if (cmd_done)  state_next = ST_DATA;
            ST_DATA:    if (data_done) state_next = ST_WAIT_CS;
            default:    state_next = state_reg;
        endcase
        if (csb_sync) state_next = ST_IDLE;
    end

    // FSM outputs: shift/commit strobes and miso.
    always_comb begin
        cmd_shift      = 1'b0;
        cmd_done       = 1'b0;
        data_shift_in  = 1'b0;
        data_shift_out = 1'b0;
        data_done      = 1'b0;
        miso           = 1'b0;
        if (!csb_sync) begin
            case (state_reg)
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_shift = 1'b1;
                        cmd_done  = (bit_cnt == CNT_W'(CMD_W - 1));
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == data_len) data_done = 1'b1;
                    else if (sck_rise)       data_shift_in = 1'b1;
                    if (!cur_write) begin
                        miso = shift_reg[REG_W-1];
                        // The fall closing the last command bit must not shift.
                        if (sck_fall && bit_cnt != '0 && !data_done) data_shift_out = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command/data shifting and bit counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE) bit_cnt <= '0;
            if (cmd_shift) begin
                cmd_reg <= cmd_full;
                bit_cnt <= cmd_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (cmd_done) shift_reg <= snap_word;
            if (data_shift_in) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (cur_write) shift_reg <= {shift_reg[REG_W-2:0], mosi_sync};
            end
            if (data_shift_out) shift_reg <= {shift_reg[REG_W-2:0], 1'b0};
        end
    end

    assign wr_commit  = data_done & cur_write;
    assign rd_commit  = data_done & ~cur_write;
    assign start_req  = shift_reg[CTRL_START_BIT];
    assign status_clr = rd_commit & cur_is_ctrl;
    assign err_set    = data_done & ((~cur_is_reg & ~cur_is_ctrl) |
                        (cur_write & op_busy & (cur_is_reg | (cur_is_ctrl & start_req))));

    // Register bank: SPI commits only when idle; a same-cycle core write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit && cur_is_reg && !op_busy && cur_addr == 4'(i)) regs[i] <= shift_reg;
                if (core_wr_en && core_wr_sel == 4'(i))                       regs[i] <= core_wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*REG_W +: REG_W] = regs[gi];
        end
    endgenerate

    // Control register, start pulse and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_mode   <= '0;
            op_start  <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            op_start <= 1'b0;
            if (wr_commit && cur_is_ctrl && !(start_req && op_busy)) begin
                op_mode  <= shift_reg[MODE_W-1:0];
                op_start <= start_req;
            end
            done_flag <= op_done | (done_flag & ~status_clr);
            err_flag  <= err_set | (err_flag & ~status_clr);
        end
    end

endmodule
